// File: rtl/slant_rx.sv
`default_nettype none
// ============================================================================
// slant_rx : four-lane slant link receive decoder (header hunt, Y/C pair writes,
//            line marker checks, link watchdog).                      Rev 1.0
// ============================================================================
module slant_rx #(
    parameter logic [23:0] FRAME1    = 24'haab155,
    parameter logic [23:0] FRAME0    = 24'haa8d55,
    parameter logic [15:0] HSYNC     = 16'ha355,
    parameter int          LINE_SYM  = 80,
    parameter int          FRAME_SYM = 76800,
    parameter int          TIMEOUT   = 64
) (
    input  logic        Cclk,
    input  logic        rstn,
    input  logic        TransValid,
    input  logic [5:0]  Trans0Data,
    input  logic [5:0]  Trans1Data,
    input  logic [5:0]  Trans2Data,
    input  logic [5:0]  Trans3Data,
    output logic        RxWEn,
    output logic [15:0] RxAddr,
    output logic [19:0] RxY,
    output logic [19:0] RxC,
    output logic        RxFrameStart,
    output logic        RxFrameId,
    output logic        RxFrameDone,
    output logic        RxLineEnd,
    output logic        RxErr,
    output logic [7:0]  RxErrCnt,
    output logic        RxLocked
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        DATA  = 2'd1,
        LSYNC = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [23:0]     hdr_sr;
    logic [23:0]     hdr_shift;
    logic [16:0]     sym_idx;
    logic [6:0]      line_cnt;
    logic [3:0]      bit_cnt;
    logic [WD_W-1:0] wd_cnt;
    logic [19:0]     y_hold;
    logic [19:0]     lanes5;
    logic            is_marker, marker_bit, lane_bad, wd_expire, hdr_hit;
    logic            ev_start, ev_err, ev_wr, ev_hold, ev_done, ev_lend;

    assign is_marker  = (Trans0Data == Trans1Data) && (Trans1Data == Trans2Data) &&
                        (Trans2Data == Trans3Data) &&
                        ((Trans0Data == 6'h00) || (Trans0Data == 6'h3f));
    assign marker_bit = Trans0Data[0];
    assign lane_bad   = Trans0Data[5] | Trans1Data[5] | Trans2Data[5] | Trans3Data[5];
    assign lanes5     = {Trans3Data[4:0], Trans2Data[4:0], Trans1Data[4:0], Trans0Data[4:0]};
    assign hdr_shift  = is_marker ? {hdr_sr[22:0], marker_bit} : 24'h0;
    assign hdr_hit    = (hdr_shift == FRAME1) || (hdr_shift == FRAME0);
    // A strobe in the expiry cycle takes priority over the timeout.
    assign wd_expire  = !TransValid && (state != HUNT) && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign RxLocked   = (state != HUNT);

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) state <= HUNT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ev_start  = 1'b0;
        ev_err    = 1'b0;
        ev_wr     = 1'b0;
        ev_hold   = 1'b0;
        ev_done   = 1'b0;
        ev_lend   = 1'b0;
        case (state)
            HUNT: begin
                if (TransValid && hdr_hit) begin
                    ev_start  = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (TransValid) begin
                    if (lane_bad) begin
                        ev_err    = 1'b1;
                        state_nxt = HUNT;
                    end else begin
                        ev_hold = !sym_idx[0];
                        ev_wr   = sym_idx[0];
                        if (sym_idx == 17'(FRAME_SYM - 1)) begin
                            ev_done   = 1'b1;
                            state_nxt = HUNT;
                        end else if (line_cnt == 7'(LINE_SYM - 1)) begin
                            state_nxt = LSYNC;
                        end
                    end
                end else if (wd_expire) begin
                    ev_err    = 1'b1;
                    state_nxt = HUNT;
                end
            end
            LSYNC: begin
                if (TransValid) begin
                    if (!is_marker || (marker_bit != HSYNC[4'd15 - bit_cnt])) begin
                        ev_err    = 1'b1;
                        state_nxt = HUNT;
                    end else if (bit_cnt == 4'd15) begin
                        ev_lend   = 1'b1;
                        state_nxt = DATA;
                    end
                end else if (wd_expire) begin
                    ev_err    = 1'b1;
                    state_nxt = HUNT;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            RxWEn        <= 1'b0;
            RxAddr       <= 16'h0;
            RxY          <= 20'h0;
            RxC          <= 20'h0;
            RxFrameStart <= 1'b0;
            RxFrameId    <= 1'b0;
            RxFrameDone  <= 1'b0;
            RxLineEnd    <= 1'b0;
            RxErr        <= 1'b0;
            RxErrCnt     <= 8'h0;
            hdr_sr       <= 24'h0;
            sym_idx      <= 17'h0;
            line_cnt     <= 7'h0;
            bit_cnt      <= 4'h0;
            wd_cnt       <= '0;
            y_hold       <= 20'h0;
        end else begin
            RxWEn        <= ev_wr;
            RxFrameStart <= ev_start;
            RxFrameDone  <= ev_done;
            RxLineEnd    <= ev_lend;
            RxErr        <= ev_err;
            if (ev_wr) begin
                RxAddr <= sym_idx[16:1];
                RxY    <= y_hold;
                RxC    <= lanes5;
            end
            if (ev_hold)
                y_hold <= lanes5;
            if (ev_start)
                RxFrameId <= (hdr_shift == FRAME1);
            if (ev_err && (RxErrCnt != 8'hff))
                RxErrCnt <= RxErrCnt + 8'd1;

            // The matched header is consumed so the next hunt starts empty.
            if (ev_err || ev_start)
                hdr_sr <= 24'h0;
            else if ((state == HUNT) && TransValid)
                hdr_sr <= hdr_shift;

            if (ev_start) begin
                sym_idx  <= 17'h0;
                line_cnt <= 7'h0;
            end else if ((state == DATA) && TransValid && !lane_bad) begin
                sym_idx  <= (sym_idx == 17'(FRAME_SYM - 1)) ? 17'h0 : sym_idx + 17'd1;
                line_cnt <= (line_cnt == 7'(LINE_SYM - 1)) ? 7'h0 : line_cnt + 7'd1;
            end

            if (state != LSYNC)
                bit_cnt <= 4'h0;
            else if (TransValid)
                bit_cnt <= bit_cnt + 4'd1;

            if ((state == HUNT) || TransValid || ev_err)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slant_rx.sv
`default_nettype none
// Randomized bench for slant_rx: every cycle the outputs are compared against a
// symbol-level reference model, plus scenario totals derived from the frame layout.
module tb_slant_rx;

    localparam int          LINE = 80;
    localparam int          FRM  = 2048;
    localparam int          TMO  = 64;
    localparam logic [23:0] F1   = 24'haab155;
    localparam logic [23:0] F0   = 24'haa8d55;
    localparam logic [15:0] HS   = 16'ha355;

    logic        Cclk, rstn, TransValid;
    logic [5:0]  Trans0Data, Trans1Data, Trans2Data, Trans3Data;
    logic        RxWEn, RxFrameStart, RxFrameId, RxFrameDone, RxLineEnd, RxErr, RxLocked;
    logic [15:0] RxAddr;
    logic [19:0] RxY, RxC;
    logic [7:0]  RxErrCnt;
    logic [70:0] dut_vec;

    slant_rx #(
        .FRAME1(F1), .FRAME0(F0), .HSYNC(HS),
        .LINE_SYM(LINE), .FRAME_SYM(FRM), .TIMEOUT(TMO)
    ) dut (
        .Cclk(Cclk), .rstn(rstn), .TransValid(TransValid),
        .Trans0Data(Trans0Data), .Trans1Data(Trans1Data),
        .Trans2Data(Trans2Data), .Trans3Data(Trans3Data),
        .RxWEn(RxWEn), .RxAddr(RxAddr), .RxY(RxY), .RxC(RxC),
        .RxFrameStart(RxFrameStart), .RxFrameId(RxFrameId),
        .RxFrameDone(RxFrameDone), .RxLineEnd(RxLineEnd),
        .RxErr(RxErr), .RxErrCnt(RxErrCnt), .RxLocked(RxLocked)
    );

    assign dut_vec = {RxWEn, RxAddr, RxY, RxC, RxFrameStart, RxFrameId,
                      RxFrameDone, RxLineEnd, RxErr, RxErrCnt, RxLocked};

    initial begin
        Cclk = 1'b0;
        forever #5 Cclk = ~Cclk;
    end

    int n_chk = 0;
    int n_err = 0;
    int n_wr, n_le, n_fd, n_fs;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: mode 0 = hunting, 1 = data, 2 = line marker.
    int          m_mode, m_hdr, m_n, m_mk, m_idle;
    logic [19:0] m_yhold;
    logic        e_wen, e_fs, e_id, e_fd, e_le, e_err, e_locked;
    logic [15:0] e_addr;
    logic [19:0] e_y, e_c;
    logic [7:0]  e_cnt;

    task automatic model_reset();
        m_mode = 0; m_hdr = 0; m_n = 0; m_mk = 0; m_idle = 0; m_yhold = '0;
        e_wen = 0; e_fs = 0; e_id = 0; e_fd = 0; e_le = 0; e_err = 0; e_locked = 0;
        e_addr = '0; e_y = '0; e_c = '0; e_cnt = '0;
    endtask

    task automatic model_error();
        e_err = 1'b1;
        if (e_cnt != 8'hff) e_cnt = e_cnt + 8'd1;
        m_hdr = 0; m_mode = 0; m_idle = 0;
    endtask

    task automatic model_step(input logic v, input logic [23:0] l);
        logic [5:0]  a0, a1, a2, a3;
        logic        mk, b;
        logic [19:0] five;
        {a3, a2, a1, a0} = l;
        mk   = (a0 == a1) && (a1 == a2) && (a2 == a3) && (a0 == 6'h00 || a0 == 6'h3f);
        b    = a0[0];
        five = {a3[4:0], a2[4:0], a1[4:0], a0[4:0]};
        e_wen = 0; e_fs = 0; e_fd = 0; e_le = 0; e_err = 0;
        if (!v) begin
            if (m_mode != 0) begin
                m_idle++;
                if (m_idle >= TMO) model_error();
            end
        end else begin
            m_idle = 0;
            if (m_mode == 0) begin
                m_hdr = mk ? (((m_hdr << 1) | int'(b)) & 'hffffff) : 0;
                if (m_hdr == int'(F1) || m_hdr == int'(F0)) begin
                    e_fs = 1; e_id = (m_hdr == int'(F1));
                    m_hdr = 0; m_n = 0; m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (a0[5] | a1[5] | a2[5] | a3[5]) model_error();
                else begin
                    if (m_n % 2 == 0) m_yhold = five;
                    else begin
                        e_wen = 1; e_addr = 16'(m_n / 2); e_y = m_yhold; e_c = five;
                    end
                    m_n++;
                    if (m_n == FRM) begin e_fd = 1; m_mode = 0; end
                    else if (m_n % LINE == 0) begin m_mode = 2; m_mk = 0; end
                end
            end else begin
                if (!mk || b != HS[15 - m_mk]) model_error();
                else begin
                    m_mk++;
                    if (m_mk == 16) begin e_le = 1; m_mode = 1; end
                end
            end
        end
        e_locked = (m_mode != 0);
    endtask

    task automatic tick(input logic v, input logic [23:0] l);
        TransValid = v;
        {Trans3Data, Trans2Data, Trans1Data, Trans0Data} = l;
        @(posedge Cclk);
        if (!rstn) model_reset();
        else       model_step(v, l);
        @(negedge Cclk);
        check("outs", 80'(dut_vec), 80'({e_wen, e_addr, e_y, e_c, e_fs, e_id,
                                          e_fd, e_le, e_err, e_cnt, e_locked}));
        if (RxWEn)        n_wr++;
        if (RxLineEnd)    n_le++;
        if (RxFrameDone)  n_fd++;
        if (RxFrameStart) n_fs++;
    endtask

    task automatic send(input logic [23:0] l, input int g);
        for (int i = 0; i < g; i++) tick(1'b0, 24'h0);
        tick(1'b1, l);
    endtask

    function automatic int gap();
        return ($urandom_range(0, 15) == 0) ? 24 : int'($urandom_range(0, 2));
    endfunction

    function automatic logic [23:0] rand_data();
        logic [23:0] l;
        for (int i = 0; i < 4; i++) l[6*i +: 6] = 6'($urandom_range(0, 31));
        return l;
    endfunction

    task automatic send_mk(input logic b, input int g);
        send(b ? 24'hffffff : 24'h0, g);
    endtask

    task automatic clear_counts();
        n_wr = 0; n_le = 0; n_fd = 0; n_fs = 0;
    endtask

    // Idle zeros, header, then n_data data symbols with markers between lines.
    // bad_mk corrupts that marker (0-based), bad5 sets lane2 bit5 at that data index.
    task automatic frame(input logic [23:0] hdr, input int n_data, input int bad_mk,
                         input int bad5, input bit pack);
        logic [23:0] l;
        logic        b;
        int          mk_idx = 0;
        for (int i = 0; i < 3; i++) send(24'h0, gap());
        for (int i = 23; i >= 0; i--) send_mk(hdr[i], gap());
        for (int k = 0; k < n_data; k++) begin
            l = rand_data();
            if (pack && k == 0) begin l[5:0] = 6'h11; l[23:18] = 6'h1f; end
            if (pack && k == 1) begin l[5:0] = 6'h05; l[23:18] = 6'h00; end
            if (k == bad5) begin
                l[17] = 1'b1;
                send(l, gap());
                check("bit5_err", 80'(RxErr), 80'(1));
                return;
            end
            send(l, gap());
            if (pack && k == 1) begin
                check("pack_wen",  80'(RxWEn), 80'(1));
                check("pack_addr", 80'(RxAddr), 80'(0));
                check("pack_y0",   80'(RxY[4:0]), 80'(5'h11));
                check("pack_c0",   80'(RxC[4:0]), 80'(5'h05));
                check("pack_y3",   80'(RxY[19:15]), 80'(5'h1f));
                check("pack_c3",   80'(RxC[19:15]), 80'(5'h00));
            end
            if (((k + 1) % LINE == 0) && (k != FRM - 1)) begin
                for (int j = 15; j >= 0; j--) begin
                    b = HS[j] ^ ((mk_idx == bad_mk) && (j == 7));
                    send_mk(b, gap());
                    if ((mk_idx == bad_mk) && (j == 7)) begin
                        check("mk_err", 80'(RxErr), 80'(1));
                        return;
                    end
                end
                mk_idx++;
            end
        end
    endtask

    int first_err;

    initial begin
        rstn = 1'b0;
        TransValid = 1'b0;
        {Trans3Data, Trans2Data, Trans1Data, Trans0Data} = 24'h0;
        model_reset();
        tick(1'b0, 24'h0);
        tick(1'b0, 24'h0);
        check("reset_outs", 80'(dut_vec), 80'(0));
        rstn = 1'b1;

        // Good frame with known first pair
        clear_counts();
        frame(F1, FRM, -1, -1, 1'b1);
        tick(1'b0, 24'h0);
        check("good_fs",    80'(n_fs), 80'(1));
        check("good_id",    80'(RxFrameId), 80'(1));
        check("good_wr",    80'(n_wr), 80'(FRM / 2));
        check("good_le",    80'(n_le), 80'((FRM - 1) / LINE));
        check("good_fd",    80'(n_fd), 80'(1));
        check("good_errs",  80'(RxErrCnt), 80'(0));
        check("good_lock",  80'(RxLocked), 80'(0));

        // Third line marker corrupted, then FRAME0 relocks
        clear_counts();
        frame(F1, FRM, 2, -1, 1'b0);
        check("mk_cnt",  80'(RxErrCnt), 80'(1));
        check("mk_lock", 80'(RxLocked), 80'(0));
        for (int i = 0; i < 20; i++) send(rand_data(), gap());
        check("mk_wr", 80'(n_wr), 80'(3 * LINE / 2));
        clear_counts();
        frame(F0, FRM, -1, -1, 1'b0);
        check("f0_id", 80'(RxFrameId), 80'(0));
        check("f0_wr", 80'(n_wr), 80'(FRM / 2));

        // Lane2 bit5 on an odd symbol mid-line: that pair is not written
        clear_counts();
        frame(F1, FRM, -1, 41, 1'b0);
        check("b5_wr",   80'(n_wr), 80'(20));
        check("b5_cnt",  80'(RxErrCnt), 80'(2));
        check("b5_lock", 80'(RxLocked), 80'(0));

        // Watchdog: 63 idle cycles survive, a longer stall errors at cycle 64
        frame(F1, 10, -1, -1, 1'b0);
        for (int i = 0; i < 63; i++) tick(1'b0, 24'h0);
        send(rand_data(), 0);
        check("wd63_lock", 80'(RxLocked), 80'(1));
        check("wd63_cnt",  80'(RxErrCnt), 80'(2));
        first_err = -1;
        for (int i = 1; i <= 70; i++) begin
            tick(1'b0, 24'h0);
            if (RxErr && first_err < 0) first_err = i;
        end
        check("wd_cycle", 80'(first_err), 80'(TMO));
        check("wd_cnt",   80'(RxErrCnt), 80'(3));

        // Error counter saturation
        for (int i = 0; i < 254; i++) begin
            for (int j = 23; j >= 0; j--) send_mk(F0[j], 0);
            send(24'h000020, 0);
        end
        check("sat_cnt", 80'(RxErrCnt), 80'(8'hff));

        // Asynchronous reset mid-frame at pair address 1000
        clear_counts();
        frame(F1, 2002, -1, -1, 1'b0);
        check("rst_pre_wen",  80'(RxWEn), 80'(1));
        check("rst_pre_addr", 80'(RxAddr), 80'(1000));
        rstn = 1'b0;
        #1;
        check("rst_async_outs", 80'(dut_vec), 80'(0));
        tick(1'b0, 24'h0);
        tick(1'b0, 24'h0);
        rstn = 1'b1;
        clear_counts();
        for (int i = 0; i < 200; i++) send(rand_data(), gap());
        check("rst_no_wr", 80'(n_wr), 80'(0));
        check("rst_lock",  80'(RxLocked), 80'(0));
        clear_counts();
        frame(F1, FRM, -1, -1, 1'b0);
        tick(1'b0, 24'h0);
        check("post_wr", 80'(n_wr), 80'(FRM / 2));
        check("post_fd", 80'(n_fd), 80'(1));
        check("post_cnt", 80'(RxErrCnt), 80'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
